// File: rtl/out_uart_tx.sv
// Buffers 16-bit OUT words in a small FIFO and sends each one as two 8N1 UART bytes,
// low byte first, so the core never stalls on the serial line.
module out_uart_tx #(
  parameter int unsigned CLKS_PER_BIT    = 104,
  parameter int unsigned FIFO_ADDR_WIDTH = 2
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [15:0] i_data,
  input  logic        i_valid,
  output logic        o_ready,
  output logic        o_tx,
  output logic        o_busy,
  output logic        o_overflow
);

  localparam int unsigned Depth = 1 << FIFO_ADDR_WIDTH;
  localparam int unsigned BaudW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);
  localparam logic [FIFO_ADDR_WIDTH:0] CountFull = (FIFO_ADDR_WIDTH + 1)'(Depth);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  logic [15:0]                mem [Depth];
  logic [FIFO_ADDR_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_ADDR_WIDTH:0]   count_q;
  logic                       overflow_q;
  logic                       full, empty, push, pop;

  state_e         state_q, state_d;
  logic [BaudW-1:0] baud_q, baud_d;
  logic [2:0]     bit_idx_q, bit_idx_d;
  logic           byte_sel_q, byte_sel_d;
  logic [15:0]    word_q, word_d;
  logic           tx_q, tx_d;
  logic [7:0]     cur_byte;
  logic           baud_end;

  assign full     = (count_q == CountFull);
  assign empty    = (count_q == '0);
  // The full flag is the pre-edge value, so a same-edge pop never makes room for a push.
  assign push     = i_valid && !full;
  assign cur_byte = byte_sel_q ? word_q[15:8] : word_q[7:0];
  assign baud_end = (baud_q == BaudLast);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (pop && !push) begin
        count_q <= count_q - 1'b1;
      end
      if (i_valid && full) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push && !i_reset) mem[wr_ptr_q] <= i_data;
  end

  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_idx_d  = bit_idx_q;
    byte_sel_d = byte_sel_q;
    word_d     = word_q;
    tx_d       = tx_q;
    pop        = 1'b0;

    unique case (state_q)
      StIdle: begin
        tx_d = 1'b1;
        if (!empty) begin
          pop        = 1'b1;
          word_d     = mem[rd_ptr_q];
          byte_sel_d = 1'b0;
          baud_d     = '0;
          tx_d       = 1'b0;
          state_d    = StStart;
        end
      end
      StStart: begin
        if (baud_end) begin
          baud_d    = '0;
          bit_idx_d = '0;
          tx_d      = cur_byte[0];
          state_d   = StData;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      StData: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_idx_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = StStop;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = cur_byte[bit_idx_d];
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      StStop: begin
        if (baud_end) begin
          baud_d = '0;
          if (!byte_sel_q) begin
            byte_sel_d = 1'b1;
            tx_d       = 1'b0;
            state_d    = StStart;
          end else if (!empty) begin
            // Next word follows immediately with no idle bit.
            pop        = 1'b1;
            word_d     = mem[rd_ptr_q];
            byte_sel_d = 1'b0;
            tx_d       = 1'b0;
            state_d    = StStart;
          end else begin
            tx_d    = 1'b1;
            state_d = StIdle;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= StIdle;
      baud_q     <= '0;
      bit_idx_q  <= '0;
      byte_sel_q <= 1'b0;
      word_q     <= '0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_idx_q  <= bit_idx_d;
      byte_sel_q <= byte_sel_d;
      word_q     <= word_d;
      tx_q       <= tx_d;
    end
  end

  assign o_ready    = !full;
  assign o_tx       = tx_q;
  assign o_busy     = !empty || (state_q != StIdle);
  assign o_overflow = overflow_q;

endmodule
